// File: rtl/fsm_ring_seq.sv
// fsm_ring_seq: parametrised ring sequencer.
// A state register steps around NUM_STATES states, forward or backward,
// when the per-state advance request is present and the minimum dwell has
// elapsed. Supports synchronous load, one-hot decode, a wrap pulse and a
// sticky error flag for illegal loads.
// Optional feature: define FSM_RING_SEQ_LAPCNT_EN to add the laps[7:0]
// wrap counter output (forward wraps count up, backward wraps count down).
//
// Control semantics: there is no valid/ready handshake here. Each rising
// edge takes one action in priority order reset > load > advance > hold;
// en gates advance and dwell counting, adv[i] is only looked at while y==i.
module fsm_ring_seq #(
  parameter int NUM_STATES = 9,
  parameter int SW         = 4,
  parameter int MIN_DWELL  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_STATES-1:0] adv,
  input  logic                  dir,
  input  logic                  load,
  input  logic [SW-1:0]         load_val,
  output logic [SW-1:0]         y,
  output logic [NUM_STATES-1:0] onehot,
  output logic                  wrap,
  output logic                  err
`ifdef FSM_RING_SEQ_LAPCNT_EN
  ,
  output logic [7:0]            laps
`endif
);

  // Elaboration-time parameter sanity checks.
  if (NUM_STATES < 2 || NUM_STATES > 16) begin : g_bad_num_states
    $error("fsm_ring_seq: NUM_STATES must be in 2..16");
  end
  if ((2 ** SW) < NUM_STATES) begin : g_bad_sw
    $error("fsm_ring_seq: SW too narrow for NUM_STATES");
  end
  if (MIN_DWELL < 0 || MIN_DWELL > 255) begin : g_bad_dwell
    $error("fsm_ring_seq: MIN_DWELL must be in 0..255");
  end

  localparam int            DW        = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [SW-1:0] LAST      = SW'(NUM_STATES - 1);

  // Action taken on the coming edge; useful as a probe point for checkers.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_STEP = 2'd1,
    ACT_LOAD = 2'd2,
    ACT_BAD  = 2'd3
  } act_t;

  logic [SW-1:0] st, st_nxt, step_to;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic          wrap_nxt, err_nxt;
  logic          adv_cur, dwell_ok, crosses;
  act_t          act;

  // Select the advance request belonging to the current state and decode one-hot.
  always_comb begin
    adv_cur = 1'b0;
    onehot  = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (st == SW'(i)) begin
        adv_cur   = adv[i];
        onehot[i] = 1'b1;
      end
    end
  end

  // Neighbour in the chosen direction and whether that step crosses the ring boundary.
  always_comb begin
    if (dir) begin
      step_to = (st == '0) ? LAST : st - 1'b1;
    end else begin
      step_to = (st == LAST) ? '0 : st + 1'b1;
    end
    crosses  = ((st == LAST) && (step_to == '0)) || ((st == '0) && (step_to == LAST));
    // dcnt never exceeds MIN_DWELL, so equality means the dwell is satisfied.
    dwell_ok = (dcnt == DWELL_MAX);
  end

  // Next-state logic: load beats advance beats dwell counting beats hold.
  always_comb begin
    act      = ACT_HOLD;
    st_nxt   = st;
    dcnt_nxt = dcnt;
    wrap_nxt = 1'b0;
    err_nxt  = err;
    if (load) begin
      if (load_val <= LAST) begin
        act      = ACT_LOAD;
        st_nxt   = load_val;
        dcnt_nxt = '0;
      end else begin
        act     = ACT_BAD;
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (adv_cur && dwell_ok) begin
        act      = ACT_STEP;
        st_nxt   = step_to;
        dcnt_nxt = '0;
        wrap_nxt = crosses;
      end else if (!dwell_ok) begin
        dcnt_nxt = dcnt + 1'b1;
      end
    end
  end

  // State, dwell counter, wrap pulse and sticky error registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st   <= '0;
      dcnt <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      st   <= st_nxt;
      dcnt <= dcnt_nxt;
      wrap <= wrap_nxt;
      err  <= err_nxt;
    end
  end

  assign y = st;

`ifdef FSM_RING_SEQ_LAPCNT_EN
  // Lap counter: forward wraps count up, backward wraps count down, both saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      laps <= 8'd0;
    end else if (act == ACT_LOAD) begin
      laps <= 8'd0;
    end else if (act == ACT_STEP && wrap_nxt) begin
      if (!dir && laps != 8'hFF) begin
        laps <= laps + 8'd1;
      end else if (dir && laps != 8'h00) begin
        laps <= laps - 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fsm_ring_seq.sv
// Directed testbench for fsm_ring_seq: a 9-state ring with no dwell, a
// 9-state ring with MIN_DWELL=3 and a 2-state ring, sharing clock and reset.
module tb_fsm_ring_seq;

  logic       clock, reset;
  logic       en, dir, load;
  logic [8:0] adv9;
  logic [3:0] load_val;
  logic [3:0] y_m, y_d;
  logic [8:0] oh_m, oh_d;
  logic       wrap_m, err_m, wrap_d, err_d;

  logic       en2, dir2, load2;
  logic [1:0] adv2;
  logic [0:0] load_val2, y_t;
  logic [1:0] oh_t;
  logic       wrap_t, err_t;

`ifdef FSM_RING_SEQ_LAPCNT_EN
  logic [7:0] laps_m, laps_d, laps_t;
`endif

  int total = 0;
  int bad   = 0;

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  fsm_ring_seq #(.NUM_STATES(9), .SW(4), .MIN_DWELL(0)) u_dut (
    .clock(clock), .reset(reset), .en(en), .adv(adv9), .dir(dir),
    .load(load), .load_val(load_val), .y(y_m), .onehot(oh_m),
    .wrap(wrap_m), .err(err_m)
`ifdef FSM_RING_SEQ_LAPCNT_EN
    , .laps(laps_m)
`endif
  );

  fsm_ring_seq #(.NUM_STATES(9), .SW(4), .MIN_DWELL(3)) u_dwell (
    .clock(clock), .reset(reset), .en(en), .adv(adv9), .dir(dir),
    .load(load), .load_val(load_val), .y(y_d), .onehot(oh_d),
    .wrap(wrap_d), .err(err_d)
`ifdef FSM_RING_SEQ_LAPCNT_EN
    , .laps(laps_d)
`endif
  );

  fsm_ring_seq #(.NUM_STATES(2), .SW(1), .MIN_DWELL(0)) u_two (
    .clock(clock), .reset(reset), .en(en2), .adv(adv2), .dir(dir2),
    .load(load2), .load_val(load_val2), .y(y_t), .onehot(oh_t),
    .wrap(wrap_t), .err(err_t)
`ifdef FSM_RING_SEQ_LAPCNT_EN
    , .laps(laps_t)
`endif
  );

  // Driver tasks
  task tick;
    @(posedge clock);
    #1;
  endtask

  task drive_idle;
    en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'd0; adv9 = 9'd0;
    en2 = 1'b0; dir2 = 1'b0; load2 = 1'b0; load_val2 = 1'b0; adv2 = 2'd0;
  endtask

  task do_reset;
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task test_reset;
    drive_idle();
    reset = 1'b1;
    #1;
    total++; if (y_m !== 4'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", y_m); end
    total++; if (oh_m !== 9'b000000001) begin bad++; $display("FAIL reset_onehot: got %b want 000000001", oh_m); end
    total++; if (wrap_m !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", wrap_m); end
    total++; if (err_m !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_m); end
    total++; if (oh_t !== 2'b01) begin bad++; $display("FAIL reset_two_onehot: got %b want 01", oh_t); end
`ifdef FSM_RING_SEQ_LAPCNT_EN
    total++; if (laps_m !== 8'd0) begin bad++; $display("FAIL reset_laps: got %0d want 0", laps_m); end
`endif
    tick();
    reset = 1'b0;
  endtask

  task test_forward;
    int         exp_y [10];
    logic [8:0] exp_oh;
    exp_y = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 1};
    do_reset();
    en = 1'b1; dir = 1'b0; adv9 = 9'h1FF;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_oh = 9'd1 << exp_y[k];
      total++; if (y_m !== 4'(exp_y[k])) begin bad++; $display("FAIL fwd_y[%0d]: got %0d want %0d", k, y_m, exp_y[k]); end
      total++; if (oh_m !== exp_oh) begin bad++; $display("FAIL fwd_onehot[%0d]: got %b want %b", k, oh_m, exp_oh); end
      total++; if (wrap_m !== (k == 8)) begin bad++; $display("FAIL fwd_wrap[%0d]: got %b want %b", k, wrap_m, (k == 8)); end
    end
  endtask

  task test_backward;
    int   exp_y [4];
    logic exp_w [4];
    exp_y = '{8, 7, 8, 0};
    exp_w = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    en = 1'b1; dir = 1'b1; adv9 = 9'h1FF;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) dir = 1'b0;
      tick();
      total++; if (y_m !== 4'(exp_y[k])) begin bad++; $display("FAIL bwd_y[%0d]: got %0d want %0d", k, y_m, exp_y[k]); end
      total++; if (wrap_m !== exp_w[k]) begin bad++; $display("FAIL bwd_wrap[%0d]: got %b want %b", k, wrap_m, exp_w[k]); end
    end
  endtask

  task test_dwell;
    logic en_seq [5];
    int   exp_y  [5];
    en_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_y  = '{0, 0, 0, 0, 1};
    do_reset();
    adv9 = 9'b000000001;
    for (int k = 0; k < 5; k++) begin
      en = en_seq[k];
      tick();
      total++; if (y_d !== 4'(exp_y[k])) begin bad++; $display("FAIL dwell_y[%0d]: got %0d want %0d", k, y_d, exp_y[k]); end
    end
    // Build up dwell in state 1, then reload state 1: the dwell must restart.
    adv9 = 9'h1FF; en = 1'b1;
    tick();
    tick();
    load = 1'b1; load_val = 4'd1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (y_d !== ((k == 3) ? 4'd2 : 4'd1)) begin bad++; $display("FAIL dwell_reload_y[%0d]: got %0d want %0d", k, y_d, (k == 3) ? 2 : 1); end
    end
  endtask

  task test_load;
    do_reset();
    load = 1'b1; load_val = 4'd5;
    tick();
    total++; if (y_m !== 4'd5) begin bad++; $display("FAIL load5_y: got %0d want 5", y_m); end
    en = 1'b1; adv9 = 9'h1FF; load_val = 4'd2;
    tick();
    total++; if (y_m !== 4'd2) begin bad++; $display("FAIL load_prio_y: got %0d want 2", y_m); end
    total++; if (wrap_m !== 1'b0) begin bad++; $display("FAIL load_prio_wrap: got %b want 0", wrap_m); end
    total++; if (err_m !== 1'b0) begin bad++; $display("FAIL load_prio_err: got %b want 0", err_m); end
    load_val = 4'd12;
    tick();
    total++; if (y_m !== 4'd2) begin bad++; $display("FAIL bad_load_y: got %0d want 2", y_m); end
    total++; if (err_m !== 1'b1) begin bad++; $display("FAIL bad_load_err: got %b want 1", err_m); end
    load = 1'b0; en = 1'b0;
    repeat (3) tick();
    total++; if (err_m !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_m); end
    total++; if (y_m !== 4'd2) begin bad++; $display("FAIL idle_hold_y: got %0d want 2", y_m); end
    // A wrap followed by a load: the load must drop the pulse.
    load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    total++; if (y_m !== 4'd0 || wrap_m !== 1'b1) begin bad++; $display("FAIL load_then_wrap: got y=%0d w=%b want y=0 w=1", y_m, wrap_m); end
    load = 1'b1; load_val = 4'd3;
    tick();
    total++; if (y_m !== 4'd3 || wrap_m !== 1'b0) begin bad++; $display("FAIL load_clears_wrap: got y=%0d w=%b want y=3 w=0", y_m, wrap_m); end
    total++; if (err_m !== 1'b1) begin bad++; $display("FAIL err_after_load: got %b want 1", err_m); end
  endtask

  task test_async_reset;
    do_reset();
    load = 1'b1; load_val = 4'd6;
    tick();
    load_val = 4'd12;
    tick();
    load = 1'b0;
    total++; if (y_m !== 4'd6 || err_m !== 1'b1) begin bad++; $display("FAIL pre_areset: got y=%0d err=%b want y=6 err=1", y_m, err_m); end
    #3;
    reset = 1'b1;
    #1;
    total++; if (y_m !== 4'd0) begin bad++; $display("FAIL areset_y: got %0d want 0", y_m); end
    total++; if (oh_m !== 9'b000000001) begin bad++; $display("FAIL areset_onehot: got %b want 000000001", oh_m); end
    total++; if (err_m !== 1'b0 || wrap_m !== 1'b0) begin bad++; $display("FAIL areset_flags: got err=%b w=%b want 0 0", err_m, wrap_m); end
    tick();
    reset = 1'b0;
    en = 1'b1; adv9 = 9'b001000000;
    tick();
    adv9 = 9'b000000010;
    tick();
    total++; if (y_m !== 4'd0) begin bad++; $display("FAIL areset_wrong_adv: got %0d want 0", y_m); end
    adv9 = 9'b000000001;
    tick();
    total++; if (y_m !== 4'd1) begin bad++; $display("FAIL areset_adv0: got %0d want 1", y_m); end
  endtask

  task test_two_state;
    logic exp_y [6];
    logic exp_w [6];
    exp_y = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_w = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    en2 = 1'b1; dir2 = 1'b0; adv2 = 2'b11;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) dir2 = 1'b1;
      if (k == 4) adv2 = 2'b01;
      tick();
      total++; if (y_t !== exp_y[k]) begin bad++; $display("FAIL two_y[%0d]: got %0d want %0d", k, y_t, exp_y[k]); end
      total++; if (wrap_t !== exp_w[k]) begin bad++; $display("FAIL two_wrap[%0d]: got %b want %b", k, wrap_t, exp_w[k]); end
    end
  endtask

`ifdef FSM_RING_SEQ_LAPCNT_EN
  task test_laps;
    do_reset();
    en = 1'b1; dir = 1'b0; adv9 = 9'h1FF;
    repeat (27) tick();
    total++; if (y_m !== 4'd0 || laps_m !== 8'd3) begin bad++; $display("FAIL laps_fwd: got y=%0d laps=%0d want y=0 laps=3", y_m, laps_m); end
    dir = 1'b1;
    tick();
    total++; if (y_m !== 4'd8 || laps_m !== 8'd2) begin bad++; $display("FAIL laps_bwd: got y=%0d laps=%0d want y=8 laps=2", y_m, laps_m); end
    load = 1'b1; load_val = 4'd4;
    tick();
    total++; if (laps_m !== 8'd0) begin bad++; $display("FAIL laps_load: got %0d want 0", laps_m); end
    load_val = 4'd0;
    tick();
    load = 1'b0;
    tick();
    total++; if (y_m !== 4'd8 || laps_m !== 8'd0) begin bad++; $display("FAIL laps_sat0: got y=%0d laps=%0d want y=8 laps=0", y_m, laps_m); end
  endtask
`endif

  // Scenario sequence and final report
  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_forward();
    test_backward();
    test_dwell();
    test_load();
    test_async_reset();
    test_two_state();
`ifdef FSM_RING_SEQ_LAPCNT_EN
    test_laps();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_ring_seq.md
Name: fsm_ring_seq

Overview:
Parametrised ring sequencer: a state register stepping through NUM_STATES states, with one advance condition per state. Adds the following over the fixed 9-state ring FSM:
- bidirectional stepping
- synchronous load of an arbitrary state
- minimum dwell time per state
- one-hot state decode
- wrap pulse and a sticky error flag

It sits between control inputs and datapath enables; y and onehot drive downstream mux selects.

Parameters:
NUM_STATES, 9, number of ring states (2..16); legal states 0..NUM_STATES-1
SW, 4, state width; must satisfy 2**SW >= NUM_STATES (elaboration error otherwise)
MIN_DWELL, 0, minimum en-cycles spent in a state before an advance is accepted (0..255)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
en  in  1  global step enable; no state/dwell change when low (except load)
adv  in  NUM_STATES  adv[i] = advance request, honoured only while st==i
dir  in  1  0: forward (i -> i+1, last -> 0); 1: backward (i -> i-1, 0 -> last)
load  in  1  synchronous load request
load_val  in  SW  state to load
y  out  SW  current state
onehot  out  NUM_STATES  onehot[i] = (y==i)
wrap  out  1  one-cycle registered pulse after a wrap transition
err  out  1  sticky: set by illegal load_val, cleared only by reset

Behaviour:
- Reset (async assert, sync release): y=0, onehot=1, dwell counter=0, wrap=0, err=0. Reset mid-sequence aborts immediately; y reads 0 within the same cycle.
- Registers: st[SW-1:0]; dcnt (width clog2(MIN_DWELL+1), min 1).
- Priority each rising edge: reset > load > advance > hold.
- Legal load (load=1, load_val<NUM_STATES):
  - st<=load_val, dcnt<=0, wrap<=0.
  - Load ignores en and dwell.
  - Loading the current state still clears dcnt.
- Illegal load (load=1, load_val>=NUM_STATES): st and dcnt unchanged, err<=1, wrap<=0.
- Advance occurs when load=0, en=1, adv[st]=1, dcnt>=MIN_DWELL:
  - st <= next(st, dir), dcnt<=0.
  - adv bits for states other than st are ignored.
- Dwell:
  - If en=1 and no advance/load: dcnt <= dcnt+1, saturating at MIN_DWELL.
  - If en=0: dcnt holds.
  - MIN_DWELL=0: an advance is possible on the first en cycle in a state; behaviour is identical to a plain ring FSM.
  - MIN_DWELL=k: the earliest advance is on the (k+1)-th en-cycle after entry.
- next(): forward wraps NUM_STATES-1 -> 0; backward wraps 0 -> NUM_STATES-1. States never leave the legal range, including for non-power-of-2 NUM_STATES.
- wrap:
  - Asserted for exactly one cycle after an advance edge that crosses the ring boundary (last->0 forward, 0->last backward).
  - Not asserted by load.
  - Deasserted on every other edge.
- dir is sampled at the advance edge; changing dir mid-dwell is legal and affects only the next step.
- Latency: y, onehot and wrap change one clock after the qualifying edge inputs. onehot is combinational from st (no extra latency).
- NUM_STATES=2: forward and backward both toggle 0<->1, and every advance asserts wrap.

Optional Feature:
Macro FSM_RING_SEQ_LAPCNT_EN.
- Defined:
  - Adds output laps[7:0]: count of wrap events, reset to 0, saturating at 255.
  - Forward wraps increment laps; backward wraps decrement it, saturating at 0.
  - A legal load clears laps to 0.
- Undefined: no laps port, no counter logic. All other behaviour is identical.

Test Plan:
- Ring, forward: NUM_STATES=9, MIN_DWELL=0, en=1, dir=0, adv=all-ones for 10 cycles after reset.
  - Required: y = 1,2,...,8,0,1.
  - wrap=1 only in the cycle y first reads 0.
  - onehot matches y every cycle.
- Backward, wrap, dir change: reset, dir=1, adv=all-ones, 2 cycles.
  - Required: y = 8, then 7; wrap=1 in the cycle y=8.
  - Then set dir=0: y returns to 8, then 0, with wrap pulse.
- Dwell: MIN_DWELL=3, adv[0]=1 held, en toggles 1,0,1,1,1.
  - Required: y leaves 0 only on the 4th en-high cycle (y=1 after that edge).
  - dcnt holds during the en=0 cycle.
- Load priority and error: y=5 with adv[5]=1, en=1, load=1, load_val=2.
  - Required: y=2, wrap=0.
  - Next, load_val=12 (NUM_STATES=9): y stays 2, err=1.
  - err stays 1 until reset.
- Async reset mid-run: assert reset between clock edges while y=6.
  - Required: y=0, onehot=1, err=0, wrap=0 before the next edge.
  - After release, the first advance needs adv[0].
- Lap counter (macro defined): 3 full forward laps, then 1 backward wrap.
  - Required: laps=3, then 2.
  - A legal load -> laps=0.
